rtc_bus_ctrl: RTL and testbench

Peripheral-side responder for the PicoBlaze port bus. It decodes port writes from the micro into timed cycles on the RTC's multiplexed address/data bus: address phase, then a data write or read. It returns read data and status to the micro's input port. It sits between the micro wrapper's decoded outputs (`dir`, `out_port`, `writestrobe`, `read_strobe`, `actRTC`) and the RTC chip pins.

---
 rtl/rtc_pkg.sv | 10 +
 rtl/rtc_phase_timer.sv | 17 +
 rtl/rtc_bus_ctrl.sv | 136 +++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared FSM state, port map and status bit positions for the RTC bus controller.
package rtc_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2} state_t;
    localparam logic [7:0] RTC_ADDR  = 8'h00;
    localparam logic [7:0] RTC_WDATA = 8'h01;
    localparam logic [7:0] RTC_CMD   = 8'h02;
    localparam logic [7:0] RTC_STAT  = 8'h03;
    localparam int STAT_BUSY = 0;
    localparam int STAT_ERR  = 1;
endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter that holds at 1; o_done flags the last cycle of a phase.
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt > W'(1)) r_cnt <= r_cnt - W'(1);
    assign o_done = (r_cnt == W'(1));
endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: PicoBlaze port responder driving timed address/data cycles on the RTC bus.
// Optional completion interrupt (irq/irq_ack) enabled by defining RTC_DONE_IRQ_EN.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int PULSE_CYC = 10,
    parameter int GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
`ifdef RTC_DONE_IRQ_EN
    output logic       irq,
    input  logic       irq_ack,
`endif
    input  logic       act,
    input  logic [7:0] dir,
    input  logic [7:0] out_port,
    input  logic       writestrobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d
);
    localparam int CW = $clog2((PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC) + 1);

    state_t        r_state, w_next;
    logic          r_wr_op, r_err;
    logic [7:0]    r_addr, r_wdata, r_rdata, r_ad_out;
    logic          r_cs_n, r_rd_n, r_wr_n, r_a_d, r_ad_oe;
    logic [7:0]    w_ad_out, w_stat;
    logic          w_cs_n, w_rd_n, w_wr_n, w_a_d, w_ad_oe;
    logic          w_busy, w_wr, w_start, w_stat_rd, w_done, w_load;
    logic [CW-1:0] w_val;

    assign w_busy    = (r_state != S_IDLE);
    assign w_wr      = act && writestrobe;
    assign w_start   = w_wr && (dir == RTC_WDATA || dir == RTC_CMD);
    assign w_stat_rd = act && read_strobe && (dir == RTC_STAT);
    assign w_load    = (w_next != r_state);
    assign w_val     = (w_next == S_ADDR || w_next == S_DATA) ? CW'(PULSE_CYC) : CW'(GAP_CYC);

    rtc_phase_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .i_load (w_load),
        .i_val  (w_val),
        .o_done (w_done)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_ADDR;
            S_ADDR:  if (w_done) w_next = S_GAP1;
            S_GAP1:  if (w_done) w_next = S_DATA;
            S_DATA:  if (w_done) w_next = S_GAP2;
            S_GAP2:  if (w_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so pins never glitch.
    always_comb begin
        w_cs_n   = !(w_next == S_ADDR || w_next == S_DATA);
        w_a_d    = (w_next == S_DATA);
        w_wr_n   = !(w_next == S_ADDR || (w_next == S_DATA && r_wr_op));
        w_rd_n   = !(w_next == S_DATA && !r_wr_op);
        w_ad_oe  = !w_wr_n;
        w_ad_out = (w_next == S_ADDR) ? r_addr : (w_next == S_DATA && r_wr_op) ? r_wdata : 8'h00;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_a_d    <= 1'b0;
            r_ad_oe  <= 1'b0;
            r_ad_out <= 8'h00;
        end else begin
            r_cs_n   <= w_cs_n;
            r_rd_n   <= w_rd_n;
            r_wr_n   <= w_wr_n;
            r_a_d    <= w_a_d;
            r_ad_oe  <= w_ad_oe;
            r_ad_out <= w_ad_out;
        end

    // Registers are frozen while busy so the cycle in flight sees stable values.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_wr_op <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (!w_busy && w_wr && dir == RTC_ADDR) r_addr <= out_port;
            if (!w_busy && w_wr && dir == RTC_WDATA) r_wdata <= out_port;
            if (!w_busy && w_start) r_wr_op <= (dir == RTC_WDATA);
            if (r_state == S_DATA && !r_wr_op && w_done) r_rdata <= ad_in;
            r_err <= (w_start && w_busy) || (r_err && !w_stat_rd);
        end

`ifdef RTC_DONE_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_irq <= 1'b0;
        else if (r_state == S_GAP2 && w_done) r_irq <= 1'b1;
        else if (irq_ack) r_irq <= 1'b0;
    assign irq = r_irq;
`endif

    always_comb begin
        w_stat            = 8'h00;
        w_stat[STAT_BUSY] = w_busy;
        w_stat[STAT_ERR]  = r_err;
        in_port = !act ? 8'h00 : (dir == RTC_CMD) ? r_rdata : (dir == RTC_STAT) ? w_stat : 8'h00;
    end

    assign cs_n   = r_cs_n;
    assign rd_n   = r_rd_n;
    assign wr_n   = r_wr_n;
    assign a_d    = r_a_d;
    assign ad_oe  = r_ad_oe;
    assign ad_out = r_ad_out;
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed checks of the RTC bus controller with default timing.
// Covers the RTC_DONE_IRQ_EN interrupt when that macro is defined.
module tb_rtc_bus_ctrl;
    localparam int P = 10;
    localparam int G = 4;
    localparam int T = 2 * P + 2 * G;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       act = 1'b0;
    logic [7:0] dir = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       writestrobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] in_port;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in = 8'h00;
    logic       cs_n, rd_n, wr_n, a_d;
`ifdef RTC_DONE_IRQ_EN
    logic       irq;
    logic       irq_ack = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    rtc_bus_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef RTC_DONE_IRQ_EN
        .irq        (irq),
        .irq_ack    (irq_ack),
`endif
        .act        (act),
        .dir        (dir),
        .out_port   (out_port),
        .writestrobe(writestrobe),
        .read_strobe(read_strobe),
        .in_port    (in_port),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .ad_in      (ad_in),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .a_d        (a_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       act;
        logic [7:0] dir;
        logic [7:0] dat;
        logic       ws;
        logic       rs;
        logic [7:0] exp_in;
    } vec_t;
    vec_t tv[8];

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic [7:0] d, input logic [7:0] o, input logic w, input logic r);
        act = a;
        dir = d;
        out_port = o;
        writestrobe = w;
        read_strobe = r;
    endtask

    // Expected pin state for cycle k of a transaction started on the edge before k=0.
    task automatic chk_bus(input int k, input logic wop, input logic [7:0] ea, input logic [7:0] ed);
        logic pa, pd, gp, eoe;
        pa  = (k < P);
        gp  = (k >= P && k < P + G) || (k >= 2 * P + G);
        pd  = !pa && !gp;
        eoe = pa || (pd && wop);
        check($sformatf("bus_k%0d", k), 16'({cs_n, rd_n, wr_n, ad_oe}),
              16'({!(pa || pd), !(pd && !wop), !eoe, eoe}));
        if (!gp) check($sformatf("a_d_k%0d", k), 16'(a_d), 16'(pd));
        if (eoe) check($sformatf("ad_out_k%0d", k), 16'(ad_out), 16'(pa ? ea : ed));
        check("strobe_excl", 16'(!wr_n && !rd_n), 16'h0000);
        check("oe_vs_rd", 16'(ad_oe && !rd_n), 16'h0000);
    endtask

    initial begin
        tv[0] = '{1'b1, 8'h02, 8'h00, 1'b0, 1'b0, 8'h17};
        tv[1] = '{1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[2] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[3] = '{1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[4] = '{1'b0, 8'h01, 8'h77, 1'b1, 1'b0, 8'h00};
        tv[5] = '{1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00};
        tv[6] = '{1'b0, 8'h03, 8'h00, 1'b0, 1'b1, 8'h00};
        tv[7] = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("reset_bus", 16'({cs_n, rd_n, wr_n, a_d, ad_oe, ad_out}), 16'({5'b11100, 8'h00}));
        drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b0);
        #1 check("reset_stat", 16'(in_port), 16'h0000);
`ifdef RTC_DONE_IRQ_EN
        check("reset_irq", 16'(irq), 16'h0000);
`endif

        // Asynchronous reset in the middle of an address phase
        drive(1'b1, 8'h00, 8'hA5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h01, 8'h3C, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        check("mid_addr_active", 16'({cs_n, wr_n, ad_out}), 16'({2'b00, 8'hA5}));
        #1 reset_n = 1'b0;
        #1 check("async_reset_bus", 16'({cs_n, rd_n, wr_n, a_d, ad_oe, ad_out}), 16'({5'b11100, 8'h00}));
        check("async_reset_stat", 16'(in_port), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_reset_idle", 16'({cs_n, in_port}), 16'({1'b1, 8'h00}));

        // Write transaction
        drive(1'b1, 8'h00, 8'h25, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h01, 8'h59, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < T; k++) begin
            chk_bus(k, 1'b1, 8'h25, 8'h59);
            #1 check($sformatf("wr_busy_k%0d", k), 16'(in_port), 16'h0001);
`ifdef RTC_DONE_IRQ_EN
            check("irq_low", 16'(irq), 16'h0000);
            irq_ack = (k == T - 1);
`endif
            tick();
        end
        check("wr_done", 16'({cs_n, in_port}), 16'({1'b1, 8'h00}));
`ifdef RTC_DONE_IRQ_EN
        check("irq_set_wins", 16'(irq), 16'h0001);
        irq_ack = 1'b0;
        tick();
        check("irq_held", 16'(irq), 16'h0001);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("irq_acked", 16'(irq), 16'h0000);
`endif

        // Read transaction
        drive(1'b1, 8'h00, 8'h23, 1'b1, 1'b0);
        tick();
        ad_in = 8'h17;
        drive(1'b1, 8'h02, 8'h00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h02, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < T; k++) begin
            chk_bus(k, 1'b0, 8'h23, 8'h00);
            #1 check($sformatf("rdata_k%0d", k), 16'(in_port), 16'(k >= 2 * P + G ? 8'h17 : 8'h00));
            tick();
        end
        check("rd_done", 16'({cs_n, in_port}), 16'({1'b1, 8'h17}));
        ad_in = 8'h00;
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(tv[i].act, tv[i].dir, tv[i].dat, tv[i].ws, tv[i].rs);
            #1 check($sformatf("vec%0d", i), 16'(in_port), 16'(tv[i].exp_in));
            tick();
        end
        check("no_txn_act0", 16'(cs_n), 16'h0001);

        // Rejected starts while busy
        drive(1'b1, 8'h00, 8'h11, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h01, 8'h33, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < T; k++) begin
            drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b0);
            chk_bus(k, 1'b1, 8'h11, 8'h33);
            if (k == 5) drive(1'b1, 8'h01, 8'h99, 1'b1, 1'b0);
            else if (k == 6) drive(1'b1, 8'h00, 8'h44, 1'b1, 1'b0);
            else if (k == 8) begin
                read_strobe = 1'b1;
                #1 check("err_busy", 16'(in_port), 16'h0003);
            end else if (k == 9) begin
                #1 check("err_cleared", 16'(in_port), 16'h0001);
            end else if (k == 12) drive(1'b1, 8'h02, 8'h00, 1'b1, 1'b0);
            else if (k == 13) begin
                #1 check("err_again", 16'(in_port), 16'h0003);
            end else if (k == T - 1) drive(1'b1, 8'h01, 8'h66, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b1);
        #1 check("edge_start_rejected", 16'({cs_n, in_port}), 16'({1'b1, 8'h02}));
        tick();
        drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b0);
        #1 check("err_read_clear", 16'({cs_n, in_port}), 16'({1'b1, 8'h00}));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
